// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use/branch hazard detection, forwarding, stall and freeze control
// Optional statistics counters (stall_count, flush_count): define HAZARD_STATS_EN
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_beq,
  input  logic        id_jal,
  input  logic        id_jalr,
  input  logic        br_equal,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_en,
  output logic [1:0]  pc_src,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        fwd_id_a,
  output logic        fwd_id_b,
  output logic [1:0]  state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FREEZE = 2'b10
  } state_e;

  state_e state_q;

  // Shadow copy of the destination/source fields travelling down the real pipeline
  logic [4:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic       ex_rw_q, ex_mr_q;
  logic [4:0] mem_rd_q;
  logic       mem_rw_q, mem_mr_q;
  logic [4:0] wb_rd_q;
  logic       wb_rw_q;

  logic [4:0] ex_rd_d, ex_rs1_d, ex_rs2_d;
  logic       ex_rw_d, ex_mr_d;

  logic       freeze;
  logic       hazard;
  logic       stall;
  logic       redirect;
  logic       id_ex_hit;
  logic       id_mem_hit;

  // x0 is hard-wired zero, so a write to it never produces a dependency
  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  // MEM result wins over WB because it is the younger producer
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_rw, input logic m_mr,
                                         input logic [4:0] w_rd, input logic w_rw);
    if (m_rw && !m_mr && reg_hit(m_rd, rs)) return 2'b10;
    if (w_rw && reg_hit(w_rd, rs))          return 2'b01;
    return 2'b00;
  endfunction

  // Hazard detection: loads in EX stall everyone; ID-resolved transfers also wait on EX ALU results and MEM loads
  always_comb begin
    id_ex_hit  = (id_use_rs1 && reg_hit(ex_rd_q, id_rs1)) || (id_use_rs2 && reg_hit(ex_rd_q, id_rs2));
    id_mem_hit = (id_use_rs1 && reg_hit(mem_rd_q, id_rs1)) || (id_use_rs2 && reg_hit(mem_rd_q, id_rs2));
    hazard     = id_valid &&
                 ((ex_mr_q && id_ex_hit) ||
                  ((id_beq || id_jalr) && ((ex_rw_q && id_ex_hit) || (mem_mr_q && id_mem_hit))));
    freeze     = !mem_ready;
    stall      = hazard && !freeze;
    redirect   = id_valid && !freeze && !hazard && ((id_beq && br_equal) || id_jal || id_jalr);
  end

  // Next ID/EX shadow entry: a squashed or empty slot becomes an all-zero NOP
  always_comb begin
    ex_rd_d  = 5'd0;
    ex_rs1_d = 5'd0;
    ex_rs2_d = 5'd0;
    ex_rw_d  = 1'b0;
    ex_mr_d  = 1'b0;
    if (id_valid && !stall) begin
      ex_rd_d  = id_rd;
      ex_rs1_d = id_rs1;
      ex_rs2_d = id_rs2;
      ex_rw_d  = id_regwrite;
      ex_mr_d  = id_memread;
    end
  end

  // Shadow pipeline advances in lock-step with the datapath and holds while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q  <= 5'd0;
      ex_rs1_q <= 5'd0;
      ex_rs2_q <= 5'd0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      mem_rw_q <= 1'b0;
      mem_mr_q <= 1'b0;
      wb_rd_q  <= 5'd0;
      wb_rw_q  <= 1'b0;
    end else if (mem_ready) begin
      ex_rd_q  <= ex_rd_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= ex_rd_q;
      mem_rw_q <= ex_rw_q;
      mem_mr_q <= ex_mr_q;
      wb_rd_q  <= mem_rd_q;
      wb_rw_q  <= mem_rw_q;
    end
  end

  // Control FSM; leaving FREEZE goes straight to STALL if the held instruction still has a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (freeze) state_q <= ST_FREEZE;
                   else if (hazard) state_q <= ST_STALL;
        ST_STALL:  if (freeze) state_q <= ST_FREEZE;
                   else if (!hazard) state_q <= ST_RUN;
        ST_FREEZE: if (!freeze) state_q <= hazard ? ST_STALL : ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Outputs: freeze beats stall beats redirect; reset forces the idle values immediately
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = 2'b00;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    fwd_id_a    = 1'b0;
    fwd_id_b    = 1'b0;
    if (rst_n) begin
      pipe_en     = !freeze;
      pc_write    = !freeze && !hazard;
      ifid_write  = !freeze && !hazard;
      idex_bubble = stall;
      ifid_flush  = redirect;
      if (redirect) pc_src = id_jalr ? 2'b10 : 2'b01;
      fwd_a    = fwd_sel(ex_rs1_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
      fwd_b    = fwd_sel(ex_rs2_q, mem_rd_q, mem_rw_q, mem_mr_q, wb_rd_q, wb_rw_q);
      fwd_id_a = mem_rw_q && !mem_mr_q && reg_hit(mem_rd_q, id_rs1);
      fwd_id_b = mem_rw_q && !mem_mr_q && reg_hit(mem_rd_q, id_rs2);
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters for stall and flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF))    stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic       id_beq, id_jal, id_jalr, br_equal, mem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en;
  logic [1:0] pc_src, fwd_a, fwd_b, state;
  logic       fwd_id_a, fwd_id_b;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  hazard_control_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_beq(id_beq), .id_jal(id_jal), .id_jalr(id_jalr), .br_equal(br_equal),
    .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_en(pipe_en),
    .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a),
    .fwd_id_b(fwd_id_b), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
  int         m_rd[3], m_rs1[3], m_rs2[3];
  bit         m_rw[3], m_mr[3];
  logic [1:0] exp_state;
`ifdef HAZARD_STATS_EN
  int         m_stalls, m_flushes;
`endif

  function automatic bit hits(input int rd, input int rs);
    return (rd != 0) && (rd == rs);
  endfunction

  function automatic bit reads(input int stage);
    return (id_use_rs1 && hits(m_rd[stage], id_rs1)) || (id_use_rs2 && hits(m_rd[stage], id_rs2));
  endfunction

  function automatic bit m_hazard();
    bit load_use, ctl_wait;
    load_use = m_mr[0] && reads(0);
    ctl_wait = (id_beq || id_jalr) && ((m_rw[0] && reads(0)) || (m_mr[1] && reads(1)));
    return id_valid && (load_use || ctl_wait);
  endfunction

  function automatic bit m_redirect();
    return mem_ready && !m_hazard() && id_valid && ((id_beq && br_equal) || id_jal || id_jalr);
  endfunction

  function automatic logic [1:0] m_fwd(input int rs);
    if (m_rw[1] && !m_mr[1] && hits(m_rd[1], rs)) return 2'b10;
    if (m_rw[2] && hits(m_rd[2], rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Model update on each clock; reset wipes everything at once
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_rd[i] = 0; m_rs1[i] = 0; m_rs2[i] = 0; m_rw[i] = 0; m_mr[i] = 0;
      end
      exp_state = 2'b00;
`ifdef HAZARD_STATS_EN
      m_stalls = 0; m_flushes = 0;
`endif
    end else begin
      bit hz;
      hz = m_hazard();
`ifdef HAZARD_STATS_EN
      if (mem_ready && hz && m_stalls < 65535) m_stalls++;
      if (m_redirect() && m_flushes < 65535) m_flushes++;
`endif
      exp_state = !mem_ready ? 2'b10 : (hz ? 2'b01 : 2'b00);
      if (mem_ready) begin
        for (int i = 2; i > 0; i--) begin
          m_rd[i] = m_rd[i-1]; m_rs1[i] = m_rs1[i-1]; m_rs2[i] = m_rs2[i-1];
          m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
        end
        if (id_valid && !hz) begin
          m_rd[0] = id_rd; m_rs1[0] = id_rs1; m_rs2[0] = id_rs2;
          m_rw[0] = id_regwrite; m_mr[0] = id_memread;
        end else begin
          m_rd[0] = 0; m_rs1[0] = 0; m_rs2[0] = 0; m_rw[0] = 0; m_mr[0] = 0;
        end
      end
    end
  end

  // Compare every output against the model in the middle of each cycle
  always @(negedge clk) begin
    logic [14:0] e, a;
    logic [1:0]  ps;
    bit          hz, fr, rd;
    if (!rst_n) begin
      e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    end else begin
      hz = m_hazard();
      fr = !mem_ready;
      rd = m_redirect();
      ps = !rd ? 2'b00 : (id_jalr ? 2'b10 : 2'b01);
      e = {!fr && !hz, !fr && !hz, !fr, rd, !fr && hz, ps,
           m_fwd(m_rs1[0]), m_fwd(m_rs2[0]),
           m_rw[1] && !m_mr[1] && hits(m_rd[1], id_rs1),
           m_rw[1] && !m_mr[1] && hits(m_rd[1], id_rs2), exp_state};
    end
    a = {pc_write, ifid_write, pipe_en, ifid_flush, idex_bubble, pc_src,
         fwd_a, fwd_b, fwd_id_a, fwd_id_b, state};
    chk("outs{pcw,ifw,pen,fl,bub,src,fa,fb,fia,fib,st}", {17'd0, a}, {17'd0, e});
`ifdef HAZARD_STATS_EN
    chk("stall_count", {16'd0, stall_count}, m_stalls);
    chk("flush_count", {16'd0, flush_count}, m_flushes);
`endif
  end

  task automatic id_nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_beq = 0; id_jal = 0; id_jalr = 0; br_equal = 0;
  endtask

  task automatic id_set(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit rw, input bit mr, input bit u1, input bit u2);
    id_nop();
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_regwrite = rw; id_memread = mr; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    id_nop();
    mem_ready = 1;
    rst_n = 0;
    #2;
    chk("rst pc_write", pc_write, 1);
    chk("rst pipe_en", pipe_en, 1);
    chk("rst idex_bubble", idex_bubble, 0);
    chk("rst state", state, 0);
    cyc();
    rst_n = 1;

    // lw x5 ; add x6,x5,x1
    id_set(5, 1, 0, 1, 1, 1, 0);
    cyc();
    id_set(6, 5, 1, 1, 0, 1, 1);
    settle();
    chk("lu pc_write", pc_write, 0);
    chk("lu idex_bubble", idex_bubble, 1);
    cyc();
    settle();
    chk("lu released", idex_bubble, 0);
    cyc();
    id_nop();
    settle();
    chk("lu fwd_a", fwd_a, 2'b01);

    // add x5 ; sub x7,x5,x5
    cyc();
    id_set(5, 2, 3, 1, 0, 1, 1);
    cyc();
    id_set(7, 5, 5, 1, 0, 1, 1);
    settle();
    chk("alu no stall", idex_bubble, 0);
    cyc();
    id_nop();
    settle();
    chk("alu fwd_a", fwd_a, 2'b10);
    chk("alu fwd_b", fwd_b, 2'b10);

    // add x5 ; beq x5,x0 taken
    cyc();
    id_set(5, 2, 3, 1, 0, 1, 1);
    cyc();
    id_set(0, 5, 0, 0, 0, 1, 1); id_beq = 1; br_equal = 1;
    settle();
    chk("beq stall", idex_bubble, 1);
    chk("beq held src", pc_src, 2'b00);
    cyc();
    settle();
    chk("beq fwd_id_a", fwd_id_a, 1);
    chk("beq pc_src", pc_src, 2'b01);
    chk("beq flush", ifid_flush, 1);

    // jalr held by a 3-cycle memory freeze
    cyc(); id_nop(); cyc(); cyc(); cyc();
    id_set(1, 2, 0, 1, 0, 1, 0); id_jalr = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("frz pipe_en", pipe_en, 0);
      chk("frz flush", ifid_flush, 0);
      if (i > 0) chk("frz state", state, 2'b10);
      cyc();
    end
    mem_ready = 1;
    settle();
    chk("jalr pc_src", pc_src, 2'b10);
    chk("jalr flush", ifid_flush, 1);

    // writes to x0 never forward or stall
    cyc();
    id_set(0, 1, 2, 1, 0, 1, 1);
    cyc();
    id_set(0, 1, 2, 1, 0, 1, 1);
    cyc();
    id_set(0, 0, 0, 0, 0, 1, 1); id_beq = 1; br_equal = 1;
    settle();
    chk("x0 no stall", idex_bubble, 0);
    chk("x0 fwd_id_a", fwd_id_a, 0);
    cyc();
    id_set(3, 0, 0, 1, 0, 1, 1);
    settle();
    chk("x0 fwd_a", fwd_a, 2'b00);
    cyc();
    id_set(0, 1, 0, 1, 1, 1, 0);
    cyc();
    id_set(4, 0, 0, 1, 0, 1, 1);
    settle();
    chk("x0 load no stall", idex_bubble, 0);

    // reset during a two-cycle load/branch stall
    cyc(); id_nop(); cyc(); cyc(); cyc();
    id_set(5, 1, 0, 1, 1, 1, 0);
    cyc();
    id_set(0, 5, 5, 0, 0, 1, 1); id_beq = 1; br_equal = 1;
    settle();
    chk("ldbr stall1", idex_bubble, 1);
    cyc();
    settle();
    chk("ldbr stall2", idex_bubble, 1);
    chk("ldbr state", state, 2'b01);
    #1 rst_n = 0;
    #1;
    chk("arst pc_write", pc_write, 1);
    chk("arst idex_bubble", idex_bubble, 0);
    chk("arst state", state, 2'b00);
`ifdef HAZARD_STATS_EN
    chk("arst stall_count", stall_count, 0);
`endif
    rst_n = 1;
    #1;
    chk("post-rst no stall", idex_bubble, 0);
    chk("post-rst redirect", pc_src, 2'b01);

    // randomized traffic with small register numbers to provoke dependencies
    for (int n = 0; n < 1500; n++) begin
      cyc();
      id_nop();
      if ($urandom_range(0, 99) < 85) begin
        int k;
        id_set(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
        id_memread = id_regwrite && ($urandom_range(0, 2) == 0);
        k = $urandom_range(0, 5);
        id_beq = (k == 0); id_jal = (k == 1); id_jalr = (k == 2);
        br_equal = 1'($urandom);
      end
      mem_ready = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  ID-stage instruction valid.
REQ-004 id_rs1, id_rs2  in  5 each  ID source register numbers.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads the source.
REQ-006 id_rd, id_regwrite, id_memread  in  5/1/1  ID destination, write enable, load flag.
REQ-007 id_beq, id_jal, id_jalr  in  1 each  ID control-transfer decode.
REQ-008 br_equal  in  1  ID branch comparator result.
REQ-009 mem_ready  in  1  data memory ready; 0 freezes the pipeline.
REQ-010 pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-011 ifid_flush, idex_bubble  out  1 each  squash IF/ID; insert NOP into ID/EX.
REQ-012 pipe_en  out  1  ID/EX, EX/MEM and MEM/WB register enable.
REQ-013 pc_src  out  2  PC mux select: 00 PC+4, 01 branch/JAL target, 10 JALR target.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand mux select: 00 regfile, 01 WB, 10 MEM.
REQ-015 fwd_id_a, fwd_id_b  out  1 each  route MEM result into ID comparator operand.
REQ-016 state  out  2  FSM state: 00 RUN, 01 STALL, 10 FREEZE.

Function
REQ-017 Shadow pipeline SHALL hold ex_{rd,rs1,rs2,rw,mr}, mem_{rd,rw,mr} and wb_{rd,rw}; it advances when pipe_en=1; ID->EX carries a bubble (rw=mr=0) when idex_bubble=1 or id_valid=0.
REQ-018 A destination of x0 SHALL never match any source (never forwarded, never stalls).
REQ-019 Load-use hazard: ex_mr=1, ex_rd matches a used ID source -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle.
REQ-020 Branch/JALR hazard: ex_rw=1 with matching rd -> 1-cycle stall; mem_mr=1 with matching rd -> 1-cycle stall; ex load match -> 2 consecutive stall cycles.
REQ-021 fwd_a/fwd_b SHALL be 10 if mem_rw=1, mem_mr=0 and mem_rd matches the ex source; else 01 if wb_rw=1 and wb_rd matches; else 00. MEM has priority.
REQ-022 fwd_id_x=1 iff mem_rw=1, mem_mr=0 and mem_rd matches the ID source.
REQ-023 No stall and (id_beq and br_equal) or id_jal -> pc_src=01 and ifid_flush=1; id_jalr -> pc_src=10 and ifid_flush=1; otherwise pc_src=00.
REQ-024 Priority SHALL be freeze > stall > redirect; a stalled control transfer SHALL redirect only in its first non-stalled cycle.
REQ-025 mem_ready=0 -> pipe_en=0, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0; shadow state SHALL hold.
REQ-026 FSM: RUN->STALL on hazard; STALL->RUN when hazard clears; any->FREEZE when mem_ready=0; FREEZE->RUN when mem_ready=1. A hazard pending on exit from FREEZE SHALL be re-evaluated that same cycle.
REQ-027 All outputs SHALL be combinational from state, shadow registers and current inputs (zero-cycle latency).

Reset
REQ-028 rst_n=0 SHALL clear all shadow registers and counters and set state=RUN immediately, without waiting for clk.
REQ-029 Reset output values: pc_write=1, ifid_write=1, pipe_en=1, ifid_flush=0, idex_bubble=0, pc_src=00, fwd_a=fwd_b=00, fwd_id_a=fwd_id_b=0.
REQ-030 A reset asserted mid-stall or mid-freeze SHALL discard the pending hazard; the first cycle after release is RUN with no stall.

Configuration
REQ-031 HAZARD_STATS_EN defined: add outputs stall_count[15:0] and flush_count[15:0]; each increments once per stall cycle or flush cycle, saturates at 16'hFFFF, and is cleared only by reset.
REQ-032 HAZARD_STATS_EN undefined: these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 lw x5 then add x6,x5,x1 -> one cycle with pc_write=0, idex_bubble=1; next cycle fwd_a=01.
REQ-034 add x5 then sub x7,x5,x5 -> no stall; fwd_a=fwd_b=10.
REQ-035 add x5 then beq x5,x0 with br_equal=1 -> one stall cycle, then fwd_id_a=1, pc_src=01, ifid_flush=1.
REQ-036 jalr during mem_ready=0 for 3 cycles -> state=FREEZE, pipe_en=0 for 3 cycles, then pc_src=10 and ifid_flush=1.
REQ-037 Writes to x0 followed by reads of x0 -> fwd selects 00 and no stalls.
REQ-038 rst_n pulsed low during a load-use stall -> outputs take reset values asynchronously, state=00; with HAZARD_STATS_EN, stall_count=0.
